// File: rtl/mlp_feature_loader_if.sv
// Feature-in / class-out bus between the host, the loader and the printed MLP classifier.
// slave = loader side, master = host/classifier side.
interface mlp_feature_loader_if #(
  parameter int WIDTH_A  = 4,
  parameter int NUM_A    = 11,
  parameter int OUTWIDTH = 3
);
  logic                     feat_valid;
  logic [WIDTH_A-1:0]       feat_data;
  logic                     feat_ready;
  logic [NUM_A*WIDTH_A-1:0] inp;
  logic [OUTWIDTH-1:0]      cls_in;
  logic                     res_valid;
  logic [OUTWIDTH-1:0]      res_class;
  logic                     res_ready;
  logic                     busy;

  modport slave (
    input  feat_valid, feat_data, cls_in, res_ready,
    output feat_ready, inp, res_valid, res_class, busy
  );

  modport master (
    output feat_valid, feat_data, cls_in, res_ready,
    input  feat_ready, inp, res_valid, res_class, busy
  );
endinterface

// File: rtl/mlp_feature_loader.sv
// Packs nibble features into the classifier input vector, holds it for SETTLE_CYCLES
// clocks, then captures the classifier's class output and hands it back over valid/ready.
module mlp_feature_loader #(
  parameter int WIDTH_A       = 4,
  parameter int NUM_A         = 11,
  parameter int OUTWIDTH      = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mlp_feature_loader_if.slave   bus
);
  localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_A - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_RESULT} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         settle_q, settle_d;
  logic [NUM_A*WIDTH_A-1:0] inp_q, inp_d;
  logic [OUTWIDTH-1:0]      res_class_q, res_class_d;
  logic                     res_valid_q, res_valid_d;
  logic                     accept;
  logic [NUM_A-1:0]         slot_we;

  assign accept = (state_q == S_LOAD) && bus.feat_valid;

  // Only the slot addressed by idx is written; every other slot keeps its old frame value.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_A; gi++) begin : g_slot
      assign slot_we[gi] = accept && (idx_q == IDX_W'(gi));
      assign inp_d[gi*WIDTH_A +: WIDTH_A] = slot_we[gi] ? bus.feat_data
                                                        : inp_q[gi*WIDTH_A +: WIDTH_A];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    res_class_d = res_class_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            settle_d = '0;
            state_d  = S_SETTLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        // The counter holds at its terminal value; it is cleared again on SETTLE entry.
        if (settle_q == CNT_LAST) begin
          res_class_d = bus.cls_in;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      settle_q    <= '0;
      inp_q       <= '0;
      res_class_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      inp_q       <= inp_d;
      res_class_q <= res_class_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.feat_ready = (state_q == S_LOAD);
  assign bus.busy       = (state_q != S_LOAD);
  assign bus.inp        = inp_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_class  = res_class_q;
endmodule
